// File: rtl/cussen_uniq_tx.sv
// cussen_uniq_tx: streams a captured 9-entry ascending set one beat at a time.
// By default all nine entries are emitted; define CUSSEN_TX_DEDUP_EN to skip duplicates.
// Latency: the first beat is valid one cycle after start is sampled in IDLE.
// Backpressure: out_valid/out_ready; data, last and index hold while stalled.
module cussen_uniq_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  input  logic [7:0] in5,
  input  logic [7:0] in6,
  input  logic [7:0] in7,
  input  logic [7:0] in8,
  input  logic [7:0] in9,
  input  logic [3:0] unique_count,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t      state;
  logic [71:0] sbuf;      // captured set, entry k at [8k+7:8k]
  logic [3:0]  idx;       // index of the beat currently on out_data
  logic [3:0]  beat_cnt;  // beats transferred so far
  logic [71:0] in_flat;

  logic [3:0]  nidx;      // index of the beat after the current one
  logic [3:0]  nidx_sel;  // nidx clamped to a legal entry
  logic        nxt_last;  // the beat at nidx is the final one
  logic        cap_last;  // the first beat of the incoming set is the final one
  logic [3:0]  exp_cnt;   // beat count that a clean set must produce

  assign in_flat = {in9, in8, in7, in6, in5, in4, in3, in2, in1};

`ifdef CUSSEN_TX_DEDUP_EN
  logic [3:0] ucnt_q;

  // Smallest j > i whose value differs from entry i; 9 means no such entry.
  function automatic logic [3:0] next_of(input logic [71:0] v, input logic [3:0] i);
    logic [3:0] r;
    int         ii;
    ii = int'(i);
    r  = 4'd9;
    for (int j = 8; j >= 1; j--) begin
      if (j > ii && v[j*8 +: 8] != v[ii*8 +: 8]) begin
        r = j[3:0];
      end
    end
    return r;
  endfunction

  // Dedup walk: jump over the run of equal values following the current beat.
  always_comb begin
    nidx     = next_of(sbuf, idx);
    nidx_sel = (nidx > 4'd8) ? 4'd8 : nidx;
    nxt_last = (next_of(sbuf, nidx_sel) == 4'd9);
    cap_last = (next_of(in_flat, 4'd0) == 4'd9);
    exp_cnt  = ucnt_q;
  end
`else
  logic unused_ucnt;
  assign unused_ucnt = ^unique_count;

  // Plain walk: every entry is a beat, the ninth is last.
  always_comb begin
    nidx     = idx + 4'd1;
    nidx_sel = (nidx > 4'd8) ? 4'd8 : nidx;
    nxt_last = (nidx_sel == 4'd8);
    cap_last = 1'b0;
    exp_cnt  = 4'd9;
  end
`endif

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sbuf      <= '0;
      idx       <= '0;
      beat_cnt  <= '0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef CUSSEN_TX_DEDUP_EN
      ucnt_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            sbuf      <= in_flat;
`ifdef CUSSEN_TX_DEDUP_EN
            ucnt_q    <= unique_count;
`endif
            beat_cnt  <= '0;
            err       <= 1'b0;
            idx       <= '0;
            out_data  <= in1;
            out_valid <= 1'b1;
            out_last  <= cap_last;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_valid && out_ready) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              idx      <= nidx_sel;
              out_data <= sbuf[nidx_sel*8 +: 8];
              out_last <= nxt_last;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          err   <= (beat_cnt != exp_cnt);
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cussen_uniq_tx.sv
// Bench for cussen_uniq_tx: directed sets plus random sorted sets with random backpressure.
// Inputs driven and outputs sampled on the falling edge.
// Expected beats come from a run-collapsing model of the captured set.
module tb_cussen_uniq_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in1, in2, in3, in4, in5, in6, in7, in8, in9;
  logic [3:0] unique_count;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;
  logic [7:0] v [9];

  cussen_uniq_tx dut (
    .clk(clk), .rst(rst), .start(start),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
    .in6(in6), .in7(in7), .in8(in8), .in9(in9),
    .unique_count(unique_count),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_set();
    in1 = v[0]; in2 = v[1]; in3 = v[2]; in4 = v[3]; in5 = v[4];
    in6 = v[5]; in7 = v[6]; in8 = v[7]; in9 = v[8];
  endtask

  task automatic scramble();
    in1 = 8'($urandom); in2 = 8'($urandom); in3 = 8'($urandom);
    in4 = 8'($urandom); in5 = 8'($urandom); in6 = 8'($urandom);
    in7 = 8'($urandom); in8 = 8'($urandom); in9 = 8'($urandom);
    unique_count = 4'($urandom);
  endtask

  task automatic load_ref();
    v[0] = 1; v[1] = 1; v[2] = 3; v[3] = 4; v[4] = 4;
    v[5] = 5; v[6] = 6; v[7] = 8; v[8] = 9;
  endtask

  task automatic rand_set();
    int x;
    x = $urandom_range(0, 60);
    for (int i = 0; i < 9; i++) begin
      if (i > 0 && ($urandom % 3) != 0) x = x + $urandom_range(1, 30);
      if (x > 255) x = 255;
      v[i] = 8'(x);
    end
  endtask

  // mode: 0 ready held high, 1 ready pattern 1,0,0 repeating, 2 random ready.
  // stop_after >= 0 pulses reset while that beat index is on the output.
  task automatic run_set(input int ucnt, input int mode, input int stop_after);
    int q[$];
    int exp_cnt;
    int exp_err;
    int k;
    int cyc;
    logic rdy;
    q.delete();
`ifdef CUSSEN_TX_DEDUP_EN
    q.push_back(int'(v[0]));
    for (int j = 1; j < 9; j++) if (v[j] != v[j-1]) q.push_back(int'(v[j]));
    exp_cnt = ucnt;
`else
    for (int j = 0; j < 9; j++) q.push_back(int'(v[j]));
    exp_cnt = 9;
`endif
    exp_err = (q.size() != exp_cnt) ? 1 : 0;

    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_last", out_last, 0);
    chk("idle_done", done, 0);
    drive_set();
    unique_count = 4'(ucnt);
    start = 1'b1;
    out_ready = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    scramble();
    chk("err_cleared", err, 0);
    chk("busy_send", busy, 1);

    k = 0;
    cyc = 0;
    while (k < q.size() && cyc < 300) begin
      chk("valid_held", out_valid, 1);
      chk("beat_data", out_data, q[k]);
      chk("beat_last", out_last, (k == q.size() - 1) ? 1 : 0);
      chk("no_early_done", done, 0);
      if (stop_after >= 0 && k == stop_after) begin
        rst = 1'b1;
        start = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("post_rst_done", done, 0);
          chk("post_rst_valid", out_valid, 0);
        end
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((cyc % 3) == 0);
        default: rdy = 1'($urandom);
      endcase
      out_ready = rdy;
      start = 1'($urandom);
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    if (k < q.size()) begin
      chk("stream_timeout", k, q.size());
      start = 1'b0;
      return;
    end

    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_valid", out_valid, 0);
    chk("done_last", out_last, 0);
    start = 1'($urandom);
    out_ready = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    chk("done_cleared", done, 0);
    chk("idle_after_busy", busy, 0);
    chk("idle_after_valid", out_valid, 0);
    chk("err_flag", err, exp_err);
    @(negedge clk);
    chk("err_sticky", err, exp_err);
    chk("stays_idle", out_valid, 0);
  endtask

  initial begin
    int uc;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) v[i] = 8'(i);
    drive_set();
    unique_count = 4'd0;
    #2;
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data", out_data, 0);
    chk("reset_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    load_ref(); run_set(7, 0, -1);      // consecutive beats
    load_ref(); run_set(7, 1, -1);      // 1,0,0 ready pattern
    for (int i = 0; i < 9; i++) v[i] = 8'hFF;
    run_set(1, 0, -1);                  // all-equal set
    load_ref(); run_set(5, 0, -1);      // wrong count raises err
    load_ref(); run_set(7, 0, -1);      // next start clears err
    load_ref(); run_set(7, 0, 3);       // reset mid-stream
    load_ref(); run_set(7, 2, -1);      // restart from beat 1

    for (int t = 0; t < 40; t++) begin
      int n;
      rand_set();
      n = 1;
      for (int j = 1; j < 9; j++) if (v[j] != v[j-1]) n++;
      uc = (($urandom % 4) == 0) ? $urandom_range(0, 15) : n;
      run_set(uc, $urandom_range(0, 2), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cussen_uniq_tx.md
CUSSEN_UNIQ_TX -- requirements
Module: cussen_uniq_tx

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request to capture a sorted set; sampled only in IDLE.
REQ-004 SHALL have ports in1..in9  input  8 each  sorted set, ascending, in1 smallest.
REQ-005 SHALL have port unique_count  input  4  distinct-value count reported by the sorter.
REQ-006 SHALL have port out_data  output  8  current stream value.
REQ-007 SHALL have port out_valid  output  1  out_data is valid.
REQ-008 SHALL have port out_ready  input  1  downstream accepts; a beat transfers when out_valid&&out_ready at a rising edge.
REQ-009 SHALL have port out_last  output  1  marks the final beat of the set.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last beat transfers.
REQ-012 SHALL have port err  output  1  count mismatch flag, sticky until the next accepted start.

Function
REQ-013 SHALL implement states IDLE, SEND, DONE, all registered.
REQ-014 IDLE with start=1 SHALL capture in1..in9 into buf[0..8], capture unique_count, clear the beat counter and err, set idx=0, and go to SEND.
REQ-015 out_valid SHALL assert in the first cycle after the edge that samples start, with out_data=buf[idx].
REQ-016 The next index nidx SHALL be the smallest j>idx with buf[j]!=buf[idx]. If no such j<=8 exists, the current beat is last.
REQ-017 out_last SHALL be high in SEND exactly when the current beat is last.
REQ-018 On each transfer the beat counter (4-bit) SHALL increment. If not last, idx<=nidx and the block stays in SEND. If last, it goes to DONE.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_last and idx SHALL hold stable.
REQ-020 out_valid SHALL never deassert in SEND without a transfer.
REQ-021 DONE SHALL last one cycle with done=1, set err=1 if the beat counter != the captured unique_count, then return to IDLE.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 Captured values SHALL be unaffected by input changes after capture.
REQ-024 Unsorted input is outside contract; only adjacent-equal runs collapse, with no other defined guarantee.
REQ-025 out_valid, out_last and done SHALL be 0 in IDLE.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, out_valid=0, out_last=0, busy=0, done=0, err=0, out_data=8'd0, idx=0, beat counter=0.
REQ-027 Reset mid-stream SHALL abandon the set with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-028 Macro CUSSEN_TX_DEDUP_EN defined: behaviour per REQ-016 (duplicates skipped), with the err check per REQ-021.
REQ-029 Macro CUSSEN_TX_DEDUP_EN undefined: nidx=idx+1 and last is idx==8, so all 9 values are emitted including duplicates. err SHALL be set if the beat count != 9, and unique_count SHALL be ignored.

Verification
REQ-030 Set {1,1,3,4,4,5,6,8,9}, unique_count=7, out_ready=1 held, DEDUP_EN -> beats 1,3,4,5,6,8,9 on consecutive cycles, last on 9, done next cycle, err=0.
REQ-031 Same set with out_ready toggled 1,0,0,1,... -> identical beat sequence, out_data stable during stalls, no beat lost or repeated.
REQ-032 All nine inputs 8'hFF, unique_count=1 -> a single beat 255 with out_last=1, done, err=0.
REQ-033 Set {1,1,3,4,4,5,6,8,9} with unique_count=5 -> 7 beats, err=1 after done, err cleared by the next start.
REQ-034 rst pulsed after the third beat -> out_valid drops asynchronously, no done. A new start then streams from beat 1.
REQ-035 DEDUP_EN undefined, set {1,1,3,4,4,5,6,8,9} -> 9 beats 1,1,3,4,4,5,6,8,9, last on 9, err=0.
